// File: rtl/mini_src_pkg.sv
// Shared opcode constants, FSM state encoding and instruction classes for the mini-SRC control unit.
// Imported by the opcode-class decoder and the control FSM.
package mini_src_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU code used for address and branch-target arithmetic
  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_F3   = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_E2   = 4'd7,
    S_E3   = 4'd8,
    S_E4   = 4'd9,
    S_E5   = 4'd10,
    S_HALT = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_RALU, CLS_IALU, CLS_MULDIV, CLS_UNARY, CLS_BR,
    CLS_JAL, CLS_JR, CLS_IN, CLS_OUT, CLS_MFLO, CLS_MFHI, CLS_NOP, CLS_HALT
  } opclass_t;

  typedef struct packed {
    logic       pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, inc_pc;
    logic       pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
    logic       read, write;
    logic       gra, grb, grc, rin, rout, ba_out, r15_in;
    logic [4:0] alu;
  } ctrl_t;

  // Final execute state of each class; the FSM leaves it for F0 (or HALT)
  function automatic state_t last_estate(opclass_t cls);
    case (cls)
      CLS_LD:                        return S_E5;
      CLS_ST:                        return S_E4;
      CLS_LDI, CLS_RALU, CLS_IALU:   return S_E2;
      CLS_MULDIV, CLS_BR:            return S_E3;
      CLS_UNARY, CLS_JAL:            return S_E1;
      default:                       return S_E0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle: instruction/condition inputs, strobes and ALU code out.
// master = control unit side, slave = datapath side.
interface control_unit_if;
  logic [31:0] IR_Data;
  logic        CON_out;
  logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic        Read, Write;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, R15_in;
  logic [4:0]  alu_instruction_bits;
  logic        run;

  modport master (
    input  IR_Data, CON_out,
    output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
    output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
    output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, R15_in,
    output alu_instruction_bits, run
  );

  modport slave (
    output IR_Data, CON_out,
    input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
    input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
    input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, R15_in,
    input  alu_instruction_bits, run
  );
endinterface

// File: rtl/cu_opclass_decode.sv
// Maps a 5-bit opcode onto the instruction class that selects the execute sequence.
// Purely combinational; unassigned opcodes fall into the nop class.
module cu_opclass_decode
  import mini_src_pkg::*;
(
  input  logic [4:0] opcode,
  output opclass_t   opclass
);

  always_comb begin
    opclass = CLS_NOP;
    case (opcode)
      OP_LD:   opclass = CLS_LD;
      OP_LDI:  opclass = CLS_LDI;
      OP_ST:   opclass = CLS_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
               opclass = CLS_RALU;
      OP_ADDI, OP_ANDI, OP_ORI:
               opclass = CLS_IALU;
      OP_DIV, OP_MUL:
               opclass = CLS_MULDIV;
      OP_NEG, OP_NOT:
               opclass = CLS_UNARY;
      OP_BR:   opclass = CLS_BR;
      OP_JAL:  opclass = CLS_JAL;
      OP_JR:   opclass = CLS_JR;
      OP_IN:   opclass = CLS_IN;
      OP_OUT:  opclass = CLS_OUT;
      OP_MFLO: opclass = CLS_MFLO;
      OP_MFHI: opclass = CLS_MFHI;
      OP_HALT: opclass = CLS_HALT;
      default: opclass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini-SRC control unit: fetch F0-F3 then class-specific execute states E0-E5, halt and reset states.
// Strobes are decoded from the current state and IR opcode; clr aborts any instruction.
module control_unit
  import mini_src_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  control_unit_if.master bus
);

  state_t     state;
  opclass_t   cls;
  ctrl_t      c;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = bus.IR_Data[31:27];
  assign unused_ir = ^bus.IR_Data[26:0];

  cu_opclass_decode u_decode (
    .opcode  (opcode),
    .opclass (cls)
  );

  function automatic state_t exec_next(state_t cur, state_t nxt, opclass_t k);
    if (cur != last_estate(k)) return nxt;
    return (k == CLS_HALT) ? S_HALT : S_F0;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:   state <= S_F0;
        S_F0:    state <= S_F1;
        S_F1:    state <= S_F2;
        S_F2:    state <= S_F3;
        S_F3:    state <= S_E0;
        S_E0:    state <= exec_next(S_E0, S_E1, cls);
        S_E1:    state <= exec_next(S_E1, S_E2, cls);
        S_E2:    state <= exec_next(S_E2, S_E3, cls);
        S_E3:    state <= exec_next(S_E3, S_E4, cls);
        S_E4:    state <= exec_next(S_E4, S_E5, cls);
        S_E5:    state <= S_F0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    c = '0;
    case (state)
      S_F0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
      S_F1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; end
      S_F2: begin c.read = 1'b1; c.mdr_in = 1'b1; end
      S_F3: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_E0: begin
        case (cls)
          CLS_RALU, CLS_IALU: begin c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          CLS_LDI, CLS_LD, CLS_ST: begin
            c.grb = 1'b1; c.rout = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
          end
          CLS_MULDIV: begin c.gra = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          CLS_UNARY: begin c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu = opcode; end
          CLS_BR:    begin c.gra = 1'b1; c.rout = 1'b1; end
          CLS_JR:    begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
          CLS_JAL:   begin c.pc_out = 1'b1; c.r15_in = 1'b1; end
          CLS_IN:    begin c.inport_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CLS_OUT:   begin c.gra = 1'b1; c.rout = 1'b1; c.outport_in = 1'b1; end
          CLS_MFHI:  begin c.hi_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CLS_MFLO:  begin c.lo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          default: ;
        endcase
      end
      S_E1: begin
        case (cls)
          CLS_RALU:   begin c.grc = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu = opcode; end
          CLS_IALU:   begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = opcode; end
          CLS_LDI, CLS_LD, CLS_ST: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD; end
          CLS_MULDIV: begin c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu = opcode; end
          CLS_UNARY:  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CLS_BR:     begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          CLS_JAL:    begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
          default: ;
        endcase
      end
      S_E2: begin
        case (cls)
          CLS_RALU, CLS_IALU, CLS_LDI: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CLS_LD, CLS_ST: begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
          CLS_MULDIV:     begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
          CLS_BR:         begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD; end
          default: ;
        endcase
      end
      S_E3: begin
        case (cls)
          CLS_LD:     c.read = 1'b1;
          // MDR is loaded from the bus here, so Read must stay low
          CLS_ST:     begin c.gra = 1'b1; c.rout = 1'b1; c.mdr_in = 1'b1; end
          CLS_MULDIV: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
          CLS_BR:     begin c.zlow_out = 1'b1; c.pc_in = bus.CON_out; end
          default: ;
        endcase
      end
      S_E4: begin
        case (cls)
          CLS_LD:  begin c.read = 1'b1; c.mdr_in = 1'b1; end
          CLS_ST:  c.write = 1'b1;
          default: ;
        endcase
      end
      S_E5: begin
        if (cls == CLS_LD) begin
          c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.PC_in      = c.pc_in;
  assign bus.IR_in      = c.ir_in;
  assign bus.Y_in       = c.y_in;
  assign bus.Z_in       = c.z_in;
  assign bus.HI_in      = c.hi_in;
  assign bus.LO_in      = c.lo_in;
  assign bus.MAR_in     = c.mar_in;
  assign bus.MDR_in     = c.mdr_in;
  assign bus.OutPort_in = c.outport_in;
  assign bus.IncPC      = c.inc_pc;
  assign bus.PC_out     = c.pc_out;
  assign bus.Zhigh_out  = c.zhigh_out;
  assign bus.Zlow_out   = c.zlow_out;
  assign bus.HI_out     = c.hi_out;
  assign bus.LO_out     = c.lo_out;
  assign bus.MDR_out    = c.mdr_out;
  assign bus.InPort_out = c.inport_out;
  assign bus.C_out      = c.c_out;
  assign bus.Read       = c.read;
  assign bus.Write      = c.write;
  assign bus.Gra        = c.gra;
  assign bus.Grb        = c.grb;
  assign bus.Grc        = c.grc;
  assign bus.Rin        = c.rin;
  assign bus.Rout       = c.rout;
  assign bus.BAout      = c.ba_out;
  assign bus.R15_in     = c.r15_in;
  assign bus.alu_instruction_bits = c.alu;
  assign bus.run        = (state != S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-opcode cycle-by-cycle strobe sequences built from the instruction
// rules, compared against the DUT for directed cases and randomized instruction streams.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  control_unit_if cu();

  control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (cu)
  );

  // One bit per strobe, MSB first in this order
  localparam logic [26:0] PCI  = 27'h1 << 26, IRI  = 27'h1 << 25, YI   = 27'h1 << 24;
  localparam logic [26:0] ZI   = 27'h1 << 23, HII  = 27'h1 << 22, LOI  = 27'h1 << 21;
  localparam logic [26:0] MARI = 27'h1 << 20, MDRI = 27'h1 << 19, OPI  = 27'h1 << 18;
  localparam logic [26:0] INC  = 27'h1 << 17, PCO  = 27'h1 << 16, ZHO  = 27'h1 << 15;
  localparam logic [26:0] ZLO  = 27'h1 << 14, HIO  = 27'h1 << 13, LOO  = 27'h1 << 12;
  localparam logic [26:0] MDRO = 27'h1 << 11, INO  = 27'h1 << 10, CO   = 27'h1 << 9;
  localparam logic [26:0] RD   = 27'h1 << 8,  WR   = 27'h1 << 7,  GRA  = 27'h1 << 6;
  localparam logic [26:0] GRB  = 27'h1 << 5,  GRC  = 27'h1 << 4,  RIN  = 27'h1 << 3;
  localparam logic [26:0] ROUT = 27'h1 << 2,  BAO  = 27'h1 << 1,  R15  = 27'h1;

  logic [26:0] em[$];
  logic [4:0]  ea[$];

  function automatic logic [26:0] observed();
    return {cu.PC_in, cu.IR_in, cu.Y_in, cu.Z_in, cu.HI_in, cu.LO_in, cu.MAR_in, cu.MDR_in,
            cu.OutPort_in, cu.IncPC, cu.PC_out, cu.Zhigh_out, cu.Zlow_out, cu.HI_out,
            cu.LO_out, cu.MDR_out, cu.InPort_out, cu.C_out, cu.Read, cu.Write,
            cu.Gra, cu.Grb, cu.Grc, cu.Rin, cu.Rout, cu.BAout, cu.R15_in};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [26:0] m, input logic [4:0] a);
    em.push_back(m);
    ea.push_back(a);
  endtask

  // Expected per-cycle strobes for one instruction: fetch, then its execute steps
  task automatic build(input logic [4:0] op, input logic con);
    em.delete();
    ea.delete();
    push(PCO | MARI | INC | ZI, 5'd0);
    push(ZLO | PCI | RD, 5'd0);
    push(RD | MDRI, 5'd0);
    push(MDRO | IRI, 5'd0);
    if (op <= 5'd2) begin
      push(GRB | ROUT | BAO | YI, 5'd0);
      push(CO | ZI, 5'd3);
      if (op == 5'd1) push(ZLO | GRA | RIN, 5'd0);
      else            push(ZLO | MARI, 5'd0);
      if (op == 5'd0) begin
        push(RD, 5'd0);
        push(RD | MDRI, 5'd0);
        push(MDRO | GRA | RIN, 5'd0);
      end else if (op == 5'd2) begin
        push(GRA | ROUT | MDRI, 5'd0);
        push(WR, 5'd0);
      end
    end else if (op <= 5'd14) begin
      push(GRB | ROUT | YI, 5'd0);
      push(((op <= 5'd11) ? (GRC | ROUT) : CO) | ZI, op);
      push(ZLO | GRA | RIN, 5'd0);
    end else if (op <= 5'd16) begin
      push(GRA | ROUT | YI, 5'd0);
      push(GRB | ROUT | ZI, op);
      push(ZLO | LOI, 5'd0);
      push(ZHO | HII, 5'd0);
    end else if (op <= 5'd18) begin
      push(GRB | ROUT | ZI, op);
      push(ZLO | GRA | RIN, 5'd0);
    end else if (op == 5'd19) begin
      push(GRA | ROUT, 5'd0);
      push(PCO | YI, 5'd0);
      push(CO | ZI, 5'd3);
      push(ZLO | (con ? PCI : 27'h0), 5'd0);
    end else if (op == 5'd20) begin
      push(PCO | R15, 5'd0);
      push(GRA | ROUT | PCI, 5'd0);
    end else if (op == 5'd21) push(GRA | ROUT | PCI, 5'd0);
    else if (op == 5'd22)     push(INO | GRA | RIN, 5'd0);
    else if (op == 5'd23)     push(GRA | ROUT | OPI, 5'd0);
    else if (op == 5'd24)     push(LOO | GRA | RIN, 5'd0);
    else if (op == 5'd25)     push(HIO | GRA | RIN, 5'd0);
    else                      push(27'h0, 5'd0);
  endtask

  // Runs the first n steps (n<0: all) of the expected sequence; caller is at edge+1 in F0
  task automatic run_instr(input logic [4:0] op, input logic con, input int n);
    int steps;
    build(op, con);
    cu.IR_Data = {op, 27'($urandom)};
    cu.CON_out = con;
    steps = (n < 0) ? em.size() : n;
    for (int i = 0; i < steps; i++) begin
      #1;
      check($sformatf("op%0d step%0d strobes", op, i), 32'(observed()), 32'(em[i]));
      check($sformatf("op%0d step%0d alu", op, i), 32'(cu.alu_instruction_bits), 32'(ea[i]));
      check($sformatf("op%0d step%0d run", op, i), 32'(cu.run), 32'd1);
      if (i != steps - 1 || n < 0) tick();
    end
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    check({tag, " strobes"}, 32'(observed()), 32'd0);
    check({tag, " alu"}, 32'(cu.alu_instruction_bits), 32'd0);
    check({tag, " run"}, 32'(cu.run), 32'd1);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    check_reset_state("rst");
    clr = 1'b0;
    tick();
  endtask

  initial begin
    cu.IR_Data = 32'h0;
    cu.CON_out = 1'b0;
    tick();
    do_reset();

    run_instr(5'd3, 1'b0, -1);
    run_instr(5'd0, 1'b0, -1);
    run_instr(5'd19, 1'b0, -1);
    run_instr(5'd19, 1'b1, -1);
    run_instr(5'd31, 1'b1, -1);

    // st aborted in E3: no Write may ever appear, then RST and a clean fetch
    run_instr(5'd2, 1'b0, 8);
    clr = 1'b1;
    tick();
    check_reset_state("st-abort");
    clr = 1'b0;
    tick();
    run_instr(5'd20, 1'b0, -1);

    run_instr(5'd27, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("halt%0d strobes", i), 32'(observed()), 32'd0);
      check($sformatf("halt%0d run", i), 32'(cu.run), 32'd0);
      tick();
    end
    do_reset();

    for (int k = 0; k < 150; k++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr(op, 1'($urandom), -1);
    end

    run_instr(5'd27, 1'b0, -1);
    #1;
    check("final halt run", 32'(cu.run), 32'd0);
    do_reset();
    run_instr(5'd16, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
